// File: rtl/ram64_arbiter.sv
// Purpose: two-port arbiter/sequencer for RAM64. Port 0 is the CPU data side,
//   port 1 the DMA/loader side. Requests are serialised into single-cycle RAM
//   accesses using round-robin or fixed (port 0 first) priority.
// Latency: request seen in IDLE cycle T -> gnt in T+1 -> rvalid/rdata in T+2.
// Backpressure: a requester holds req and its op stable until gnt; one access
//   per 2 cycles; the losing port simply keeps waiting.
// Ports: clk/rst_n (sync, active-low); per port x in {0,1}: reqx, wex, addrx,
//   wdatax in, gntx, rvalidx, rdatax out; RAM side: ram_in, ram_load,
//   ram_address out, ram_out in (combinational read path).
module ram64_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] op_addr;
  logic              op_we;
  logic [DATA_W-1:0] op_wdata;
  logic              op_id;
  logic              rr_last;   // port served most recently
  logic              win_vld;
  logic              win_id;
  logic              access;

  always_comb begin
    state_nxt = state;
    win_vld   = 1'b0;
    win_id    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          win_vld = 1'b1;
          if (req0 && req1)
            win_id = (FIXED_PRIO != 0) ? 1'b0 : ~rr_last;
          else
            win_id = req1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_addr  <= '0;
      op_we    <= 1'b0;
      op_wdata <= '0;
      op_id    <= 1'b0;
      rr_last  <= 1'b1;   // "last served port 1" makes port 0 win first
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      state   <= state_nxt;
      rvalid0 <= (state == ACCESS) && !op_we && !op_id;
      rvalid1 <= (state == ACCESS) && !op_we &&  op_id;
      if (win_vld) begin
        op_id    <= win_id;
        op_addr  <= win_id ? addr1  : addr0;
        op_we    <= win_id ? we1    : we0;
        op_wdata <= win_id ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        rr_last <= op_id;
        // Each port's rdata only moves on its own reads.
        if (!op_we && !op_id) rdata0 <= ram_out;
        if (!op_we &&  op_id) rdata1 <= ram_out;
      end
    end
  end

  // Qualifying with rst_n lets a reset landing on an ACCESS cycle kill the
  // write strobe and grant in that same cycle.
  assign access      = (state == ACCESS) && rst_n;
  assign ram_load    = access && op_we;
  assign gnt0        = access && !op_id;
  assign gnt1        = access &&  op_id;
  // Held from the op registers, so these keep their last values in IDLE.
  assign ram_address = op_addr;
  assign ram_in      = op_wdata;

endmodule

// File: tb/tb_ram64_arbiter.sv
module tb_ram64_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [5:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;

  // round-robin instance (_r) and fixed-priority instance (_f) share stimulus
  logic        gnt0_r, gnt1_r, rvalid0_r, rvalid1_r, load_r;
  logic [15:0] rdata0_r, rdata1_r, in_r, out_r;
  logic [5:0]  address_r;
  logic        gnt0_f, gnt1_f, rvalid0_f, rvalid1_f, load_f;
  logic [15:0] rdata0_f, rdata1_f, in_f, out_f;
  logic [5:0]  address_f;

  logic [15:0] mem_r [64];
  logic [15:0] mem_f [64];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ram64_arbiter #(.ADDR_W(6), .DATA_W(16), .FIXED_PRIO(0)) dut_r (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_r), .rvalid0(rvalid0_r), .rdata0(rdata0_r),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_r), .rvalid1(rvalid1_r), .rdata1(rdata1_r),
    .ram_in(in_r), .ram_load(load_r), .ram_address(address_r), .ram_out(out_r));

  ram64_arbiter #(.ADDR_W(6), .DATA_W(16), .FIXED_PRIO(1)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_f), .rvalid0(rvalid0_f), .rdata0(rdata0_f),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_f), .rvalid1(rvalid1_f), .rdata1(rdata1_f),
    .ram_in(in_f), .ram_load(load_f), .ram_address(address_f), .ram_out(out_f));

  // RAM64 models: combinational read, write on clk edge while load=1
  assign out_r = mem_r[address_r];
  assign out_f = mem_f[address_f];
  always @(posedge clk) begin
    if (load_r) mem_r[address_r] <= in_r;
    if (load_f) mem_f[address_f] <= in_f;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (gnt0_r !== 1'b0 || gnt1_r !== 1'b0) $display("FAIL reset_gnt got %b%b want 00", gnt0_r, gnt1_r); else n_pass++;
    n_checks++; if (rvalid0_r !== 1'b0 || rvalid1_r !== 1'b0) $display("FAIL reset_rvalid got %b%b want 00", rvalid0_r, rvalid1_r); else n_pass++;
    n_checks++; if (rdata0_r !== 16'h0 || rdata1_r !== 16'h0) $display("FAIL reset_rdata got %h %h want 0 0", rdata0_r, rdata1_r); else n_pass++;
    n_checks++; if (address_r !== 6'd0 || in_r !== 16'h0 || load_r !== 1'b0) $display("FAIL reset_ram got a=%0d in=%h ld=%b want 0 0 0", address_r, in_r, load_r); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd5; wdata0 = 16'hBEEF;
    tick();
    n_checks++; if (gnt0_r !== 1'b1 || gnt1_r !== 1'b0) $display("FAIL wr_gnt got %b%b want 10", gnt0_r, gnt1_r); else n_pass++;
    n_checks++; if (load_r !== 1'b1 || address_r !== 6'd5 || in_r !== 16'hBEEF) $display("FAIL wr_ram got ld=%b a=%0d in=%h want 1 5 beef", load_r, address_r, in_r); else n_pass++;
    req0 = 1'b0;
    tick();
    n_checks++; if (load_r !== 1'b0 || gnt0_r !== 1'b0 || rvalid0_r !== 1'b0) $display("FAIL wr_after got ld=%b gnt=%b rv=%b want 000", load_r, gnt0_r, rvalid0_r); else n_pass++;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
    tick();
    n_checks++; if (gnt0_r !== 1'b1 || load_r !== 1'b0) $display("FAIL rd_gnt got gnt=%b ld=%b want 1 0", gnt0_r, load_r); else n_pass++;
    req0 = 1'b0;
    tick();
    n_checks++; if (rvalid0_r !== 1'b1 || rdata0_r !== 16'hBEEF) $display("FAIL rd_data got rv=%b d=%h want 1 beef", rvalid0_r, rdata0_r); else n_pass++;
    tick();
    n_checks++; if (rvalid0_r !== 1'b0 || rdata0_r !== 16'hBEEF) $display("FAIL rd_hold got rv=%b d=%h want 0 beef", rvalid0_r, rdata0_r); else n_pass++;
  endtask

  // Both ports read continuously: RR alternates 0,1,..; fixed serves port 0
  // until req0 drops.
  task automatic test_arbitration();
    logic exp_g0_r, exp_g1_r, exp_g0_f;
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd2;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_g0_r = (k % 4 == 1);
      exp_g1_r = (k % 4 == 3);
      exp_g0_f = (k % 2 == 1);
      n_checks++; if (gnt0_r !== exp_g0_r || gnt1_r !== exp_g1_r) $display("FAIL rr_gnt k=%0d got %b%b want %b%b", k, gnt0_r, gnt1_r, exp_g0_r, exp_g1_r); else n_pass++;
      n_checks++; if (gnt0_f !== exp_g0_f || gnt1_f !== 1'b0) $display("FAIL fix_gnt k=%0d got %b%b want %b0", k, gnt0_f, gnt1_f, exp_g0_f); else n_pass++;
      if (k == 2) begin
        n_checks++; if (rvalid0_r !== 1'b1 || rdata0_r !== 16'h1001) $display("FAIL rr_rd0 got rv=%b d=%h want 1 1001", rvalid0_r, rdata0_r); else n_pass++;
      end
      if (k == 4) begin
        n_checks++; if (rvalid1_r !== 1'b1 || rdata1_r !== 16'h1002) $display("FAIL rr_rd1 got rv=%b d=%h want 1 1002", rvalid1_r, rdata1_r); else n_pass++;
      end
    end
    req0 = 1'b0;
    tick();
    n_checks++; if (gnt1_f !== 1'b1 || gnt0_f !== 1'b0) $display("FAIL fix_gnt1 got %b%b want 01", gnt0_f, gnt1_f); else n_pass++;
    n_checks++; if (gnt1_r !== 1'b1 || gnt0_r !== 1'b0) $display("FAIL rr_gnt1 got %b%b want 01", gnt0_r, gnt1_r); else n_pass++;
    req1 = 1'b0;
    tick();
    n_checks++; if (rvalid1_f !== 1'b1 || rdata1_f !== 16'h1002) $display("FAIL fix_rd1 got rv=%b d=%h want 1 1002", rvalid1_f, rdata1_f); else n_pass++;
    tick();
  endtask

  task automatic test_cross_port();
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'd63; wdata1 = 16'h1234;
    tick();
    n_checks++; if (gnt1_r !== 1'b1 || gnt0_r !== 1'b0 || load_r !== 1'b1) $display("FAIL x_wr got g0=%b g1=%b ld=%b want 0 1 1", gnt0_r, gnt1_r, load_r); else n_pass++;
    req1 = 1'b0;
    tick();
    n_checks++; if (rvalid1_r !== 1'b0) $display("FAIL x_wr_rv got %b want 0", rvalid1_r); else n_pass++;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd63;
    tick();
    n_checks++; if (gnt0_r !== 1'b1) $display("FAIL x_rd_gnt got %b want 1", gnt0_r); else n_pass++;
    req0 = 1'b0;
    tick();
    n_checks++; if (rvalid0_r !== 1'b1 || rdata0_r !== 16'h1234) $display("FAIL x_rd got rv=%b d=%h want 1 1234", rvalid0_r, rdata0_r); else n_pass++;
    n_checks++; if (rvalid1_r !== 1'b0 || rdata1_r !== 16'h1002) $display("FAIL x_other got rv=%b d=%h want 0 1002", rvalid1_r, rdata1_r); else n_pass++;
    tick();
  endtask

  task automatic test_reset_in_access();
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd10; wdata0 = 16'hAAAA;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if (load_r !== 1'b0 || gnt0_r !== 1'b0) $display("FAIL rst_acc got ld=%b gnt=%b want 0 0", load_r, gnt0_r); else n_pass++;
    req0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (gnt0_r !== 1'b0 || rvalid0_r !== 1'b0 || address_r !== 6'd0) $display("FAIL rst_after got gnt=%b rv=%b a=%0d want 0 0 0", gnt0_r, rvalid0_r, address_r); else n_pass++;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd10;
    tick();
    req0 = 1'b0;
    tick();
    n_checks++; if (rvalid0_r !== 1'b1 || rdata0_r !== 16'h100A) $display("FAIL rst_rd got rv=%b d=%h want 1 100a", rvalid0_r, rdata0_r); else n_pass++;
    tick();
  endtask

  task automatic test_withdraw();
    logic seen;
    seen = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd2;
    tick();
    n_checks++; if (gnt1_r !== 1'b1) $display("FAIL wd_gnt1 got %b want 1", gnt1_r); else n_pass++;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd7;
    #3;
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (gnt0_r || rvalid0_r) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL wd_port0 got activity=%b want 0", seen); else n_pass++;
    n_checks++; if (rdata0_r !== 16'h100A) $display("FAIL wd_rdata0 got %h want 100a", rdata0_r); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_r[i] = 16'h1000 + 16'(i);
      mem_f[i] = 16'h1000 + 16'(i);
    end
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_write_read();
    test_arbitration();
    test_cross_port();
    test_reset_in_access();
    test_withdraw();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
